// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: operand forwarding select, load-use / long-op RAW / WAW stall,
// and per-register countdown scoreboard. Optional stall statistics under HAZARD_STATS_EN.
module hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int REG_W   = 5,
    parameter int LAT_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    // id_valid qualifies every ID-stage input; stall is the same-cycle "not ready" reply to it.
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]         id_rs_used,
    input  logic [REG_W-1:0]           id_ex_rd,
    input  logic                       id_ex_mem_read,
    input  logic [REG_W-1:0]           ex_mem_rd,
    input  logic                       ex_mem_reg_write,
    input  logic [REG_W-1:0]           mem_wb_rd,
    input  logic                       mem_wb_reg_write,
    input  logic                       long_issue,
    input  logic [REG_W-1:0]           long_rd,
    input  logic [LAT_W-1:0]           long_lat,
    output logic [2*NUM_SRC-1:0]       fwd_sel,
    output logic                       stall,
    output logic                       busy_any
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                load_use_cycles
`endif
);

    localparam int NUM_REGS = 1 << REG_W;

    logic [LAT_W-1:0]    cnt_q [NUM_REGS];
    logic [LAT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [REG_W-1:0]    src_idx [NUM_SRC];
    logic                raw_hazard;
    logic                load_use;
    logic                waw_hazard;
    logic                issue_ok;
    logic [LAT_W-1:0]    lat_eff;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src_idx[k] = id_rs[k*REG_W +: REG_W];
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
        assign busy[r] = (cnt_q[r] != '0);
    end

    assign busy_any = |busy;

    always_comb begin
        fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs_used[k] && (src_idx[k] != '0)) begin
                if (ex_mem_reg_write && (src_idx[k] == ex_mem_rd)) begin
                    fwd_sel[2*k +: 2] = 2'b10;
                end else if (mem_wb_reg_write && (src_idx[k] == mem_wb_rd)) begin
                    fwd_sel[2*k +: 2] = 2'b01;
                end
            end
        end
    end

    // Hazards look at pre-edge counters, so an issue never sees its own destination as busy.
    always_comb begin
        raw_hazard = 1'b0;
        load_use   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs_used[k] && (src_idx[k] != '0)) begin
                if (busy[src_idx[k]]) begin
                    raw_hazard = 1'b1;
                end
                if (id_ex_mem_read && (src_idx[k] == id_ex_rd)) begin
                    load_use = 1'b1;
                end
            end
        end
        waw_hazard = long_issue && busy[long_rd];
        stall      = id_valid && (raw_hazard || load_use || waw_hazard);
        issue_ok   = id_valid && long_issue && !stall && (long_rd != '0);
        lat_eff    = (long_lat == '0) ? LAT_W'(1) : long_lat;
    end

    // A fresh load wins over the decrement for the register being issued.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_W'(1)) : '0;
            if (issue_ok && (long_rd == REG_W'(r))) begin
                cnt_d[r] = lat_eff;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] load_use_cycles_q;
    logic [31:0] load_use_cycles_d;

    always_comb begin
        stall_cycles_d    = stall_cycles_q + {31'b0, stall};
        load_use_cycles_d = load_use_cycles_q + {31'b0, (id_valid && load_use)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q    <= '0;
            load_use_cycles_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            load_use_cycles_q <= load_use_cycles_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign load_use_cycles = load_use_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with literal expectations plus a per-cycle
// comparison against a register-ready-time model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int REG_W   = 5;
    localparam int LAT_W   = 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                     id_valid = 1'b0;
    logic [NUM_SRC*REG_W-1:0] id_rs = '0;
    logic [NUM_SRC-1:0]       id_rs_used = '0;
    logic [REG_W-1:0]         id_ex_rd = '0;
    logic                     id_ex_mem_read = 1'b0;
    logic [REG_W-1:0]         ex_mem_rd = '0;
    logic                     ex_mem_reg_write = 1'b0;
    logic [REG_W-1:0]         mem_wb_rd = '0;
    logic                     mem_wb_reg_write = 1'b0;
    logic                     long_issue = 1'b0;
    logic [REG_W-1:0]         long_rd = '0;
    logic [LAT_W-1:0]         long_lat = '0;
    logic [2*NUM_SRC-1:0]     fwd_sel;
    logic                     stall;
    logic                     busy_any;
`ifdef HAZARD_STATS_EN
    logic [31:0]              stall_cycles;
    logic [31:0]              load_use_cycles;
`endif

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .LAT_W(LAT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rs_used       (id_rs_used),
        .id_ex_rd         (id_ex_rd),
        .id_ex_mem_read   (id_ex_mem_read),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .long_issue       (long_issue),
        .long_rd          (long_rd),
        .long_lat         (long_lat),
        .fwd_sel          (fwd_sel),
        .stall            (stall),
        .busy_any         (busy_any)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles     (stall_cycles),
        .load_use_cycles  (load_use_cycles)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each register has the absolute cycle at which it becomes free.
    longint cyc = 0;
    longint ready_at [32];
    int     exp_stall_cycles = 0;
    int     exp_load_use_cycles = 0;

    function automatic logic [REG_W-1:0] src(input int k);
        logic [NUM_SRC*REG_W-1:0] v;
        v = id_rs;
        return v[k*REG_W +: REG_W];
    endfunction

    function automatic bit m_busy(input logic [REG_W-1:0] r);
        return (r != 0) && (cyc < ready_at[int'(r)]);
    endfunction

    function automatic bit m_load_use();
        bit hit = 0;
        for (int k = 0; k < NUM_SRC; k++)
            if (id_rs_used[k] && id_ex_mem_read && id_ex_rd != 0 && src(k) == id_ex_rd) hit = 1;
        return id_valid && hit;
    endfunction

    function automatic bit m_stall();
        bit hit = 0;
        for (int k = 0; k < NUM_SRC; k++)
            if (id_rs_used[k] && m_busy(src(k))) hit = 1;
        if (long_issue && m_busy(long_rd)) hit = 1;
        return (id_valid && hit) || m_load_use();
    endfunction

    function automatic logic [2*NUM_SRC-1:0] m_fwd();
        logic [2*NUM_SRC-1:0] f = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs_used[k] && src(k) != 0) begin
                if (ex_mem_reg_write && src(k) == ex_mem_rd)      f[2*k +: 2] = 2'b10;
                else if (mem_wb_reg_write && src(k) == mem_wb_rd) f[2*k +: 2] = 2'b01;
            end
        end
        return f;
    endfunction

    function automatic bit m_busy_any();
        bit b = 0;
        for (int r = 1; r < 32; r++) if (m_busy(REG_W'(r))) b = 1;
        return b;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
            exp_stall_cycles    = 0;
            exp_load_use_cycles = 0;
        end else begin
            if (m_stall()) exp_stall_cycles++;
            if (m_load_use()) exp_load_use_cycles++;
            if (id_valid && long_issue && !m_stall() && long_rd != 0)
                ready_at[int'(long_rd)] = cyc + 1 + ((long_lat == 0) ? 1 : longint'(long_lat));
            cyc++;
        end
    end

    // scoreboard compare: every cycle, away from the active edge
    always @(negedge clk) begin
        chk("cmp_stall", {31'b0, stall}, {31'b0, m_stall()});
        chk("cmp_fwd", {28'b0, fwd_sel}, {28'b0, m_fwd()});
        chk("cmp_busy_any", {31'b0, busy_any}, {31'b0, m_busy_any()});
`ifdef HAZARD_STATS_EN
        chk("cmp_stall_cycles", stall_cycles, exp_stall_cycles);
        chk("cmp_load_use_cycles", load_use_cycles, exp_load_use_cycles);
`endif
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs = '0; id_rs_used = '0; id_ex_rd = '0; id_ex_mem_read = 0;
        ex_mem_rd = '0; ex_mem_reg_write = 0; mem_wb_rd = '0; mem_wb_reg_write = 0;
        long_issue = 0; long_rd = '0; long_lat = '0;
    endtask

    task automatic issue(input logic [REG_W-1:0] rd, input logic [LAT_W-1:0] lat);
        id_valid = 1; long_issue = 1; long_rd = rd; long_lat = lat;
        id_rs = '0; id_rs_used = '0;
    endtask

    task automatic read_src0(input logic [REG_W-1:0] r);
        id_valid = 1; long_issue = 0; id_rs = {5'd0, r}; id_rs_used = 2'b01;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        step(); step();
        chk("reset_busy_any", {31'b0, busy_any}, 0);
        chk("reset_stall", {31'b0, stall}, 0);
        chk("reset_fwd", {28'b0, fwd_sel}, 0);
        reset = 0;
        step();

        // forwarding priority and x0
        id_valid = 1; id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
        ex_mem_rd = 5; ex_mem_reg_write = 1; mem_wb_rd = 5; mem_wb_reg_write = 1;
        #1 chk("fwd_exmem_prio", {28'b0, fwd_sel}, 32'h2);
        step();
        id_rs = {5'd0, 5'd0};
        #1 chk("fwd_x0", {28'b0, fwd_sel}, 32'h0);
        step();
        id_rs = {5'd6, 5'd5}; id_rs_used = 2'b11; mem_wb_rd = 6;
        #1 chk("fwd_both_srcs", {28'b0, fwd_sel}, 32'h6);
        step();
        id_rs_used = 2'b01;
        #1 chk("fwd_src1_unused", {28'b0, fwd_sel}, 32'h2);
        step();
        clear_inputs();

        // load-use
        id_valid = 1; id_ex_mem_read = 1; id_ex_rd = 7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
        #1 chk("load_use_stall", {31'b0, stall}, 1);
        step();
        id_ex_mem_read = 0; id_ex_rd = 0;
        #1 chk("load_use_one_cycle", {31'b0, stall}, 0);
        step();
        id_ex_mem_read = 1; id_ex_rd = 7; id_rs_used = 2'b01;
        #1 chk("load_use_unused", {31'b0, stall}, 0);
        step();
        clear_inputs();

        // long-op RAW: x9, latency 3
        issue(9, 3);
        #1 chk("raw_issue_nostall", {31'b0, stall}, 0);
        step();
        read_src0(9);
        for (int i = 0; i < 3; i++) begin
            #1 chk("raw_stall", {31'b0, stall}, 1);
            chk("raw_busy_any", {31'b0, busy_any}, 1);
            step();
        end
        #1 chk("raw_stall_end", {31'b0, stall}, 0);
        chk("raw_busy_any_end", {31'b0, busy_any}, 0);
        step();

        // WAW: second issue to busy x9 must stall and leave the countdown alone
        issue(9, 3);
        #1 step();
        issue(9, 5);
        #1 chk("waw_stall", {31'b0, stall}, 1);
        step();
        read_src0(9);
        #1 chk("waw_remaining_1", {31'b0, stall}, 1);
        step();
        #1 chk("waw_remaining_2", {31'b0, stall}, 1);
        step();
        #1 chk("waw_done", {31'b0, stall}, 0);
        step();

        // latency 0 behaves as 1
        issue(3, 0);
        #1 step();
        read_src0(3);
        #1 chk("lat0_stall", {31'b0, stall}, 1);
        step();
        #1 chk("lat0_end", {31'b0, stall}, 0);
        step();

        // reading its own destination does not stall the issuing instruction
        issue(4, 2);
        id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01;
        #1 chk("own_dest_nostall", {31'b0, stall}, 0);
        step();
        read_src0(4);
        #1 chk("own_dest_next_1", {31'b0, stall}, 1);
        step();
        #1 chk("own_dest_next_2", {31'b0, stall}, 1);
        step();
        #1 chk("own_dest_next_end", {31'b0, stall}, 0);
        step();

        // reset mid-countdown
        issue(9, 3);
        #1 step();
        clear_inputs();
        step();
        reset = 1;
        #1 chk("reset_mid_busy_any", {31'b0, busy_any}, 0);
        step();
        reset = 0;
        read_src0(9);
        #1 chk("post_reset_nostall", {31'b0, stall}, 0);
        chk("post_reset_busy_any", {31'b0, busy_any}, 0);
        step();
        clear_inputs();

        // statistics scenario: 3 RAW stall cycles plus one load-use cycle
        reset = 1;
        step();
        reset = 0;
        issue(9, 3);
        #1 step();
        read_src0(9);
        repeat (3) step();
        id_rs = {5'd0, 5'd7}; id_ex_mem_read = 1; id_ex_rd = 7;
        #1 chk("stats_load_use_stall", {31'b0, stall}, 1);
        step();
        clear_inputs();
        step();
`ifdef HAZARD_STATS_EN
        chk("stats_stall_cycles", stall_cycles, 4);
        chk("stats_load_use_cycles", load_use_cycles, 1);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
